// File: rtl/frame_buffer_pkg.sv
// Shared types and defaults for the frame-buffer swap controller.
package frame_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    RENDER    = 2'd2,
    WAIT_SWAP = 2'd3
  } fb_state_t;

  localparam int DEF_PIXEL_W = 4;
  localparam int DEF_H_RES   = 320;
  localparam int DEF_V_RES   = 240;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_buffer_swap_ctrl_pixel_address_gen.sv
// Linear frame address (y*H_RES + x) and bounds check for one coordinate pair.
module pixel_address_gen #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 17
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               in_range_o
);

  assign addr_o     = ADDR_W'(y_i) * ADDR_W'(H_RES) + ADDR_W'(x_i);
  assign in_range_o = (int'(x_i) < H_RES) && (int'(y_i) < V_RES);

endmodule

// File: rtl/frame_buffer_swap_ctrl.sv
// Double/triple frame-buffer swap controller: routes GPU writes to the back
// buffer, pipelines front-buffer reads to the DAC, and swaps on vsync rise.
module frame_buffer_swap_ctrl
  import frame_buffer_pkg::*;
#(
  parameter int NUM_BUFFERS = 2,
  parameter int PIXEL_W     = DEF_PIXEL_W,
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int COORD_W     = 10,
  localparam int ADDR_W     = $clog2(H_RES*V_RES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [COORD_W-1:0]             gpu_x,
  input  logic [COORD_W-1:0]             gpu_y,
  input  logic [PIXEL_W-1:0]             gpu_data,
  input  logic                           gpu_we,
  input  logic                           gpu_done,
  output logic                           gpu_start,
  input  logic [COORD_W-1:0]             vga_x,
  input  logic [COORD_W-1:0]             vga_y,
  input  logic                           vga_enable,
  input  logic                           vga_vs,
  output logic [NUM_BUFFERS-1:0]         buf_we,
  output logic [ADDR_W-1:0]              buf_waddr,
  output logic [PIXEL_W-1:0]             buf_wdata,
  output logic [ADDR_W-1:0]              buf_raddr,
  input  logic [NUM_BUFFERS*PIXEL_W-1:0] buf_rdata,
  output logic [PIXEL_W-1:0]             pix_out,
  output logic [1:0]                     wr_idx,
  output logic [1:0]                     disp_idx,
  output logic [15:0]                    repeat_count,
  output logic [15:0]                    drop_count
);

  if (NUM_BUFFERS != 2 && NUM_BUFFERS != 3) begin : g_bad_num_buffers
    $error("frame_buffer_swap_ctrl: NUM_BUFFERS must be 2 or 3");
  end

  localparam bit TRIPLE = (NUM_BUFFERS == 3);

  fb_state_t   state_q, state_d;
  logic        vs_q;
  logic [1:0]  wr_idx_q, wr_idx_d;
  logic [1:0]  disp_idx_q, disp_idx_d;
  logic [1:0]  rdy_idx_q, rdy_idx_d;
  logic        rdy_valid_q, rdy_valid_d;
  logic [15:0] repeat_q, repeat_d;
  logic [15:0] drop_q, drop_d;
  logic        vs_rise, publish, swapped;

  assign vs_rise = vga_vs & ~vs_q;

  // Swap resolves before publish so a frame consumed this cycle is never dropped.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    disp_idx_d  = disp_idx_q;
    rdy_idx_d   = rdy_idx_q;
    rdy_valid_d = rdy_valid_q;
    repeat_d    = repeat_q;
    drop_d      = drop_q;
    publish     = 1'b0;
    swapped     = 1'b0;
    case (state_q)
      IDLE:  state_d = START;
      START: if (!gpu_done) state_d = RENDER;
      RENDER: begin
        if (gpu_done) begin
          if (TRIPLE) begin
            publish = 1'b1;
            state_d = START;
          end else begin
            state_d = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (vs_rise) begin
          swapped    = 1'b1;
          wr_idx_d   = disp_idx_q;
          disp_idx_d = wr_idx_q;
          state_d    = START;
        end
      end
      default: state_d = IDLE;
    endcase
    if (TRIPLE && vs_rise && rdy_valid_q) begin
      swapped     = 1'b1;
      disp_idx_d  = rdy_idx_q;
      rdy_valid_d = 1'b0;
    end
    if (publish) begin
      rdy_idx_d   = wr_idx_q;
      rdy_valid_d = 1'b1;
      if (rdy_valid_q && !swapped) begin
        wr_idx_d = rdy_idx_q;
        drop_d   = sat_inc16(drop_q);
      end else begin
        // Indices are 0..2, so the remaining one is 3 minus the other two.
        wr_idx_d = 2'd3 - disp_idx_d - wr_idx_q;
      end
    end
    if (vs_rise && !swapped) repeat_d = sat_inc16(repeat_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      wr_idx_q    <= 2'd0;
      disp_idx_q  <= 2'(NUM_BUFFERS - 1);
      rdy_idx_q   <= 2'd0;
      rdy_valid_q <= 1'b0;
      repeat_q    <= 16'd0;
      drop_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vga_vs;
      wr_idx_q    <= wr_idx_d;
      disp_idx_q  <= disp_idx_d;
      rdy_idx_q   <= rdy_idx_d;
      rdy_valid_q <= rdy_valid_d;
      repeat_q    <= repeat_d;
      drop_q      <= drop_d;
    end
  end

  assign gpu_start    = (state_q == START);
  assign wr_idx       = wr_idx_q;
  assign disp_idx     = disp_idx_q;
  assign repeat_count = repeat_q;
  assign drop_count   = drop_q;

  // ---------------- write path ----------------
  logic [ADDR_W-1:0]      gpu_addr;
  logic                   gpu_in_range, wr_accept;
  logic [NUM_BUFFERS-1:0] we_d, we_q;
  logic [ADDR_W-1:0]      waddr_q;
  logic [PIXEL_W-1:0]     wdata_q;

  pixel_address_gen #(
    .H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W), .ADDR_W(ADDR_W)
  ) u_gpu_addr (
    .x_i(gpu_x), .y_i(gpu_y), .addr_o(gpu_addr), .in_range_o(gpu_in_range)
  );

  assign wr_accept = (state_q == RENDER) && gpu_we && gpu_in_range;

  always_comb begin
    we_d = '0;
    for (int i = 0; i < NUM_BUFFERS; i++)
      we_d[i] = wr_accept && (wr_idx_q == 2'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= we_d;
      if (wr_accept) begin
        waddr_q <= gpu_addr;
        wdata_q <= gpu_data;
      end
    end
  end

  assign buf_we    = we_q;
  assign buf_waddr = waddr_q;
  assign buf_wdata = wdata_q;

  // ---------------- read path ----------------
  // Enable and buffer select ride alongside the RAM access so a swap
  // landing mid-pipeline cannot pair one buffer's data with another's select.
  logic [ADDR_W-1:0]  vga_addr;
  logic               vga_in_range;
  logic [ADDR_W-1:0]  raddr_q;
  logic [1:0]         rd_vld_q;
  logic [1:0][1:0]    rd_disp_q;
  logic [PIXEL_W-1:0] rd_sel;
  logic [PIXEL_W-1:0] pix_q;

  pixel_address_gen #(
    .H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W), .ADDR_W(ADDR_W)
  ) u_vga_addr (
    .x_i(vga_x), .y_i(vga_y), .addr_o(vga_addr), .in_range_o(vga_in_range)
  );

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_BUFFERS; i++)
      if (rd_disp_q[1] == 2'(i)) rd_sel = buf_rdata[i*PIXEL_W +: PIXEL_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raddr_q   <= '0;
      rd_vld_q  <= '0;
      rd_disp_q <= '0;
      pix_q     <= '0;
    end else begin
      if (vga_in_range) raddr_q <= vga_addr;
      rd_vld_q     <= {rd_vld_q[0], vga_enable & vga_in_range};
      rd_disp_q[0] <= disp_idx_q;
      rd_disp_q[1] <= rd_disp_q[0];
      pix_q        <= rd_vld_q[1] ? rd_sel : '0;
    end
  end

  assign buf_raddr = raddr_q;
  assign pix_out   = pix_q;

endmodule

// File: tb/tb_frame_buffer_swap_ctrl.sv
// Directed bench: a double-buffered and a triple-buffered instance driven in turn.
module tb_frame_buffer_swap_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------- double-buffered instance ----------
  logic        rst2, gwe2, gdone2, ven2, vvs2;
  logic [9:0]  gx2, gy2, vx2, vy2;
  logic [3:0]  gd2;
  logic [7:0]  rdata2;
  logic        gstart2;
  logic [1:0]  bwe2;
  logic [16:0] bwaddr2, braddr2;
  logic [3:0]  bwdata2, pix2;
  logic [1:0]  wr2, disp2;
  logic [15:0] rep2, drop2;

  frame_buffer_swap_ctrl #(.NUM_BUFFERS(2)) dut2 (
    .clk(clk), .reset(rst2),
    .gpu_x(gx2), .gpu_y(gy2), .gpu_data(gd2), .gpu_we(gwe2),
    .gpu_done(gdone2), .gpu_start(gstart2),
    .vga_x(vx2), .vga_y(vy2), .vga_enable(ven2), .vga_vs(vvs2),
    .buf_we(bwe2), .buf_waddr(bwaddr2), .buf_wdata(bwdata2),
    .buf_raddr(braddr2), .buf_rdata(rdata2), .pix_out(pix2),
    .wr_idx(wr2), .disp_idx(disp2), .repeat_count(rep2), .drop_count(drop2)
  );

  // ---------- triple-buffered instance ----------
  logic        rst3, gwe3, gdone3, ven3, vvs3;
  logic [9:0]  gx3, gy3, vx3, vy3;
  logic [3:0]  gd3;
  logic [11:0] rdata3;
  logic        gstart3;
  logic [2:0]  bwe3;
  logic [16:0] bwaddr3, braddr3;
  logic [3:0]  bwdata3, pix3;
  logic [1:0]  wr3, disp3;
  logic [15:0] rep3, drop3;

  frame_buffer_swap_ctrl #(.NUM_BUFFERS(3)) dut3 (
    .clk(clk), .reset(rst3),
    .gpu_x(gx3), .gpu_y(gy3), .gpu_data(gd3), .gpu_we(gwe3),
    .gpu_done(gdone3), .gpu_start(gstart3),
    .vga_x(vx3), .vga_y(vy3), .vga_enable(ven3), .vga_vs(vvs3),
    .buf_we(bwe3), .buf_waddr(bwaddr3), .buf_wdata(bwdata3),
    .buf_raddr(braddr3), .buf_rdata(rdata3), .pix_out(pix3),
    .wr_idx(wr3), .disp_idx(disp3), .repeat_count(rep3), .drop_count(drop3)
  );

  initial begin
    rst2 = 1'b1; gwe2 = 1'b0; gdone2 = 1'b1; ven2 = 1'b0; vvs2 = 1'b0;
    gx2 = '0; gy2 = '0; vx2 = '0; vy2 = '0; gd2 = '0; rdata2 = '0;
    rst3 = 1'b1; gwe3 = 1'b0; gdone3 = 1'b1; ven3 = 1'b0; vvs3 = 1'b0;
    gx3 = '0; gy3 = '0; vx3 = '0; vy3 = '0; gd3 = '0; rdata3 = '0;

    // ===== double buffering =====
    tick(2);
    chk("d_rst_gstart", gstart2, 0);
    chk("d_rst_bwe",    bwe2,    0);
    chk("d_rst_wr",     wr2,     0);
    chk("d_rst_disp",   disp2,   1);
    chk("d_rst_pix",    pix2,    0);
    chk("d_rst_rep",    rep2,    0);
    rst2 = 1'b0;
    tick();
    chk("d_start1", gstart2, 1);
    gwe2 = 1'b1; gx2 = 10'd5; gy2 = 10'd3; gd2 = 4'hA;   // write while in START
    tick();
    chk("d_start2", gstart2, 1);
    chk("d_start_nowrite", bwe2, 0);
    gwe2 = 1'b0; gdone2 = 1'b0;
    tick();
    chk("d_render_gstart", gstart2, 0);
    gwe2 = 1'b1;
    tick();
    chk("d_wr_bwe",   bwe2,    2'b01);
    chk("d_wr_addr",  bwaddr2, 965);
    chk("d_wr_data",  bwdata2, 4'hA);
    gx2 = 10'd320;
    tick();
    chk("d_wr_oob", bwe2, 0);
    gwe2 = 1'b0; vvs2 = 1'b1;
    tick();
    chk("d_rep_render", rep2, 1);
    vvs2 = 1'b0;
    tick();
    gdone2 = 1'b1;
    tick();
    chk("d_wait_wr",   wr2,   0);
    chk("d_wait_disp", disp2, 1);
    vvs2 = 1'b1;
    tick();
    chk("d_swap_wr",   wr2,     1);
    chk("d_swap_disp", disp2,   0);
    chk("d_swap_rep",  rep2,    1);
    chk("d_swap_gst",  gstart2, 1);

    rdata2 = {4'h3, 4'h7}; vx2 = 10'd10; vy2 = 10'd2; ven2 = 1'b1;
    tick();
    chk("d_raddr", braddr2, 650);
    tick(2);
    chk("d_pix7", pix2, 4'h7);
    ven2 = 1'b0;
    tick(3);
    chk("d_pix_blank", pix2, 0);
    ven2 = 1'b1;
    tick(3);
    chk("d_pix7_again", pix2, 4'h7);
    vx2 = 10'd400;
    tick();
    chk("d_raddr_hold", braddr2, 650);
    tick(2);
    chk("d_pix_oob", pix2, 0);

    // ===== triple buffering =====
    tick();
    chk("t_rst_wr",   wr3,   0);
    chk("t_rst_disp", disp3, 2);
    rst3 = 1'b0;
    tick();                      // IDLE -> START
    gdone3 = 1'b0;
    tick();                      // -> RENDER
    gdone3 = 1'b1;
    tick();                      // publish buffer 0
    chk("t_pub1_wr",   wr3,   1);
    chk("t_pub1_drop", drop3, 0);
    gdone3 = 1'b0;
    tick();                      // -> RENDER
    gdone3 = 1'b1;
    tick();                      // publish buffer 1, buffer 0 discarded
    chk("t_pub2_wr",   wr3,   0);
    chk("t_pub2_drop", drop3, 1);
    gdone3 = 1'b0; vvs3 = 1'b1;
    tick();
    chk("t_vs_disp", disp3, 1);
    chk("t_vs_wr",   wr3,   0);
    chk("t_vs_rep",  rep3,  0);
    vvs3 = 1'b0; gdone3 = 1'b1;
    tick();                      // publish 0, no ready frame pending
    chk("t_pub3_wr",   wr3,   2);
    chk("t_pub3_drop", drop3, 1);
    gdone3 = 1'b0;
    tick();                      // -> RENDER
    gdone3 = 1'b1; vvs3 = 1'b1;
    tick();                      // vsync and publish in the same cycle
    chk("t_sim_disp", disp3, 0);
    chk("t_sim_wr",   wr3,   1);
    chk("t_sim_drop", drop3, 1);
    chk("t_sim_rep",  rep3,  0);
    vvs3 = 1'b0; gdone3 = 1'b0;
    tick();                      // -> RENDER
    gwe3 = 1'b1; gx3 = 10'd2; gy3 = 10'd1; gd3 = 4'h5;
    tick();
    chk("t_wr_bwe",  bwe3,    3'b010);
    chk("t_wr_addr", bwaddr3, 322);
    rst3 = 1'b1;                 // reset mid-RENDER with a write in flight
    tick();
    chk("t_mid_bwe",   bwe3,    0);
    chk("t_mid_waddr", bwaddr3, 0);
    chk("t_mid_wr",    wr3,     0);
    chk("t_mid_disp",  disp3,   2);
    chk("t_mid_drop",  drop3,   0);
    chk("t_mid_rep",   rep3,    0);
    chk("t_mid_gst",   gstart3, 0);
    chk("t_mid_pix",   pix3,    0);
    rst3 = 1'b0; gwe3 = 1'b0; gdone3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vvs3 = 1'b1;
      tick();
      vvs3 = 1'b0;
      tick();
    end
    chk("t_rep3",      rep3,  3);
    chk("t_rep3_disp", disp3, 2);
    chk("t_rep3_drop", drop3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
